// File: rtl/alu_pkg.sv
// Shared definitions for the logic-unit result path.
//   SEL_*          : operation select encodings carried with each result
//   stage_state_e  : occupancy state of the result stage skid buffer
//   AluWidth       : default result width, one bit per logic-unit slice
package alu_pkg;

  localparam int unsigned AluWidth = 32;

  localparam logic [1:0] SEL_AND = 2'b00;
  localparam logic [1:0] SEL_OR  = 2'b01;
  localparam logic [1:0] SEL_XOR = 2'b10;
  localparam logic [1:0] SEL_NOT = 2'b11;

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StFull
  } stage_state_e;

endpackage

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the logic unit array, the result stage and its consumer.
//   in_*  : upstream result channel (valid/ready, result word, select tag)
//   out_* : downstream result channel with derived flags
// Optional out_parity signal exists only when ALU_PARITY_FLAG_EN is defined.
// Modports: slave = the result stage, master = the surrounding environment.
interface alu_result_stage_if #(
  parameter int unsigned WIDTH = alu_pkg::AluWidth
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic [1:0]       in_sel;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [1:0]       out_sel;
  logic             out_zero;
  logic             out_neg;
`ifdef ALU_PARITY_FLAG_EN
  logic             out_parity;
`endif

  modport slave (
    input  in_valid, in_result, in_sel, out_ready,
    output in_ready, out_valid, out_result, out_sel, out_zero, out_neg
`ifdef ALU_PARITY_FLAG_EN
    , output out_parity
`endif
  );

  modport master (
    output in_valid, in_result, in_sel, out_ready,
    input  in_ready, out_valid, out_result, out_sel, out_zero, out_neg
`ifdef ALU_PARITY_FLAG_EN
    , input out_parity
`endif
  );

endinterface

// File: rtl/alu_flag_gen.sv
// Combinational status flag generator for one result word.
//   result : result word (input)
//   zero   : result is all zeros
//   neg    : most significant bit of result
//   parity : XOR-reduction of result (only with ALU_PARITY_FLAG_EN)
module alu_flag_gen #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg
`ifdef ALU_PARITY_FLAG_EN
  ,
  output logic             parity
`endif
);

  assign zero = (result == '0);
  assign neg  = result[WIDTH-1];
`ifdef ALU_PARITY_FLAG_EN
  assign parity = ^result;
`endif

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage for the logic unit array: captures result + select through a
// valid/ready handshake, derives flags on the way in and buffers up to two beats
// (main + skid) so downstream back-pressure never drops or duplicates a result.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : alu_result_stage_if slave (in_* upstream channel, out_* downstream channel)
//   txn_count : saturating count of output handshakes since reset
// Optional feature macro: ALU_PARITY_FLAG_EN adds out_parity and its storage.
// The interface instance must be built with the same WIDTH as this module.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = AluWidth,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  alu_result_stage_if.slave  bus,
  output logic [CNT_W-1:0]   txn_count
);

  stage_state_e state_q;

  logic [WIDTH-1:0] main_result_q, skid_result_q;
  logic [1:0]       main_sel_q, skid_sel_q;
  logic             main_zero_q, skid_zero_q;
  logic             main_neg_q, skid_neg_q;
`ifdef ALU_PARITY_FLAG_EN
  logic             main_parity_q, skid_parity_q;
  logic             in_parity;
`endif
  logic [CNT_W-1:0] txn_count_q;

  logic in_zero, in_neg;
  logic accept, take;
  logic load_main_in, load_skid_in, load_main_skid;

  // Flags are derived once, at accept time, and travel with the data.
  alu_flag_gen #(
    .WIDTH (WIDTH)
  ) u_flag_gen (
    .result (bus.in_result),
    .zero   (in_zero),
    .neg    (in_neg)
`ifdef ALU_PARITY_FLAG_EN
    ,
    .parity (in_parity)
`endif
  );

  // in_ready depends only on stored state and reset, never on out_ready.
  assign bus.in_ready  = (state_q != StFull) && !rst;
  assign bus.out_valid = (state_q != StEmpty);

  assign accept = bus.in_valid && bus.in_ready;
  assign take   = bus.out_valid && bus.out_ready;

  always_comb begin
    load_main_in   = 1'b0;
    load_skid_in   = 1'b0;
    load_main_skid = 1'b0;
    unique case (state_q)
      StEmpty: load_main_in = accept;
      StOne: begin
        load_main_in = accept && take;
        load_skid_in = accept && !take;
      end
      StFull:  load_main_skid = take;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: if (accept) state_q <= StOne;
        StOne: begin
          if (accept && !take) begin
            state_q <= StFull;
          end else if (!accept && take) begin
            state_q <= StEmpty;
          end
        end
        StFull:  if (take) state_q <= StOne;
        default: state_q <= StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_result_q <= '0;
      main_sel_q    <= '0;
      main_zero_q   <= 1'b0;
      main_neg_q    <= 1'b0;
      skid_result_q <= '0;
      skid_sel_q    <= '0;
      skid_zero_q   <= 1'b0;
      skid_neg_q    <= 1'b0;
`ifdef ALU_PARITY_FLAG_EN
      main_parity_q <= 1'b0;
      skid_parity_q <= 1'b0;
`endif
    end else begin
      if (load_main_in) begin
        main_result_q <= bus.in_result;
        main_sel_q    <= bus.in_sel;
        main_zero_q   <= in_zero;
        main_neg_q    <= in_neg;
`ifdef ALU_PARITY_FLAG_EN
        main_parity_q <= in_parity;
`endif
      end else if (load_main_skid) begin
        main_result_q <= skid_result_q;
        main_sel_q    <= skid_sel_q;
        main_zero_q   <= skid_zero_q;
        main_neg_q    <= skid_neg_q;
`ifdef ALU_PARITY_FLAG_EN
        main_parity_q <= skid_parity_q;
`endif
      end
      if (load_skid_in) begin
        skid_result_q <= bus.in_result;
        skid_sel_q    <= bus.in_sel;
        skid_zero_q   <= in_zero;
        skid_neg_q    <= in_neg;
`ifdef ALU_PARITY_FLAG_EN
        skid_parity_q <= in_parity;
`endif
      end
    end
  end

  // Saturating delivered-result counter; reset wins over a take on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      txn_count_q <= '0;
    end else if (take && (txn_count_q != '1)) begin
      txn_count_q <= txn_count_q + CNT_W'(1);
    end
  end

  assign bus.out_result = main_result_q;
  assign bus.out_sel    = main_sel_q;
  assign bus.out_zero   = main_zero_q;
  assign bus.out_neg    = main_neg_q;
`ifdef ALU_PARITY_FLAG_EN
  assign bus.out_parity = main_parity_q;
`endif
  assign txn_count = txn_count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of a 2-deep FIFO with a
// saturating delivery counter.
module tb_alu_result_stage;
  import alu_pkg::*;

  localparam int unsigned W      = 32;
  localparam int unsigned CW     = 16;
  localparam int unsigned CntMax = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] txn_count;

  alu_result_stage_if #(.WIDTH(W)) bus ();

  alu_result_stage #(
    .WIDTH (W),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .txn_count (txn_count)
  );

  always #5 clk = ~clk;

  // Model: queue of {sel, result} beats still owed to the consumer.
  logic [33:0] exp_q[$];
  int unsigned exp_cnt;
  int          n_checks;
  int          n_pass;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_outputs();
    logic [31:0] r;
    check_eq("in_ready", 32'(bus.in_ready), 32'(exp_q.size() < 2 && !rst));
    check_eq("out_valid", 32'(bus.out_valid), 32'(exp_q.size() > 0));
    check_eq("txn_count", 32'(txn_count), exp_cnt);
    if (exp_q.size() > 0) begin
      r = exp_q[0][31:0];
      check_eq("out_result", bus.out_result, r);
      check_eq("out_sel", 32'(bus.out_sel), 32'(exp_q[0][33:32]));
      check_eq("out_zero", 32'(bus.out_zero), 32'(r == 32'd0));
      check_eq("out_neg", 32'(bus.out_neg), 32'(r[31]));
`ifdef ALU_PARITY_FLAG_EN
      check_eq("out_parity", 32'(bus.out_parity), 32'(^r));
`endif
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check at the negedge.
  task automatic cycle(input logic r, input logic v, input logic [31:0] d,
                       input logic [1:0] s, input logic ordy);
    bit rdy, vld;
    rst           = r;
    bus.in_valid  = v;
    bus.in_result = d;
    bus.in_sel    = s;
    bus.out_ready = ordy;
    rdy = (exp_q.size() < 2) && !r;
    vld = exp_q.size() > 0;
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      exp_cnt = 0;
    end else begin
      if (vld && ordy) begin
        void'(exp_q.pop_front());
        if (exp_cnt < CntMax) exp_cnt++;
      end
      if (v && rdy) exp_q.push_back({s, d});
    end
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    exp_cnt       = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_result = '0;
    bus.in_sel    = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);

    // Reset held two cycles with in_valid high.
    cycle(1'b1, 1'b1, 32'hDEADBEEF, 2'b10, 1'b1);
    cycle(1'b1, 1'b1, 32'hCAFEF00D, 2'b01, 1'b1);
    check_eq("rst_result", bus.out_result, 32'h0);
    check_eq("rst_sel", 32'(bus.out_sel), 32'h0);
    check_eq("rst_zero", 32'(bus.out_zero), 32'h0);
    check_eq("rst_neg", 32'(bus.out_neg), 32'h0);
`ifdef ALU_PARITY_FLAG_EN
    check_eq("rst_parity", 32'(bus.out_parity), 32'h0);
`endif
    check_eq("rst_count", 32'(txn_count), 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 2'b00, 1'b1);
    check_eq("post_rst_in_ready", 32'(bus.in_ready), 32'h1);

    // Streaming at full rate.
    cycle(1'b0, 1'b1, 32'h00000000, SEL_AND, 1'b1);
    check_eq("s0_zero", 32'(bus.out_zero), 32'h1);
    cycle(1'b0, 1'b1, 32'h80000001, SEL_OR, 1'b1);
    check_eq("s1_neg", 32'(bus.out_neg), 32'h1);
    cycle(1'b0, 1'b1, 32'hFFFFFFFF, SEL_NOT, 1'b1);
    check_eq("s2_result", bus.out_result, 32'hFFFFFFFF);
    cycle(1'b0, 1'b0, 32'h0, 2'b00, 1'b1);
    check_eq("stream_count", 32'(txn_count), 32'd3);

    // Back-pressure: fill, hold a third beat, then drain in order.
    cycle(1'b0, 1'b1, 32'hA5A5A5A5, SEL_XOR, 1'b0);
    cycle(1'b0, 1'b1, 32'h5A5A5A5A, SEL_OR, 1'b0);
    check_eq("bp_full_in_ready", 32'(bus.in_ready), 32'h0);
    cycle(1'b0, 1'b1, 32'h12345678, SEL_AND, 1'b0);
    check_eq("bp_hold_result", bus.out_result, 32'hA5A5A5A5);
    cycle(1'b0, 1'b1, 32'h12345678, SEL_AND, 1'b1);
    check_eq("bp_second", bus.out_result, 32'h5A5A5A5A);
    cycle(1'b0, 1'b1, 32'h12345678, SEL_AND, 1'b1);
    check_eq("bp_third", bus.out_result, 32'h12345678);
    cycle(1'b0, 1'b0, 32'h0, 2'b00, 1'b1);
    check_eq("bp_drained", 32'(bus.out_valid), 32'h0);

    // Reset while FULL discards both queued beats.
    cycle(1'b0, 1'b1, 32'h11111111, SEL_AND, 1'b0);
    cycle(1'b0, 1'b1, 32'h22222222, SEL_AND, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 2'b00, 1'b1);
    check_eq("midrst_valid", 32'(bus.out_valid), 32'h0);
    check_eq("midrst_count", 32'(txn_count), 32'h0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 2'b00, 1'b1);

    // Counter saturation.
    force dut.txn_count_q = 16'hFFFE;
    exp_cnt = 32'hFFFE;
    cycle(1'b0, 1'b0, 32'h0, 2'b00, 1'b0);
    release dut.txn_count_q;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, $urandom, 2'($urandom_range(0, 3)), 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 2'b00, 1'b1);
    check_eq("sat_count", 32'(txn_count), 32'hFFFF);

`ifdef ALU_PARITY_FLAG_EN
    cycle(1'b0, 1'b1, 32'h00000007, SEL_XOR, 1'b1);
    check_eq("parity_7", 32'(bus.out_parity), 32'h1);
    cycle(1'b0, 1'b1, 32'h00000003, SEL_XOR, 1'b1);
    check_eq("parity_3", 32'(bus.out_parity), 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 2'b00, 1'b1);
`endif

    // Random traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), $urandom,
            2'($urandom_range(0, 3)), ($urandom_range(0, 2) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
